// File: rtl/inst_fetch_if.sv
// Bundle of the instruction fetch stage's signals: the instruction-memory
// req/ack read port, the (inst, inst_pc) valid/ready stream towards decode,
// and the redirect request coming back from execute.
interface inst_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   // Fetch stage side
   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc,
      input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
   );

   // Memory / consumer / redirect-source side
   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc,
      output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one word read
// outstanding to a variable-latency instruction memory, and buffers returned
// words with their PCs in a DEPTH-entry queue. A redirect flushes the queue,
// and any read already in flight is squashed by waiting out its ack in DISCARD.
module inst_fetch #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic          clk,
   input  logic          rst,
   inst_fetch_if.master  bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WAIT    = 2'b01,
      DISCARD = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          req_q, req_d;
   logic          valid_q, valid_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   pc_mem_d [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];

   logic          pop_s;
   logic          push_s;
   logic          flush_s;
   logic [31:0]   redir_pc_s;
   logic [31:0]   req_pc_inc_s;
   logic [CW:0]   count_pop_s;
   logic [CW:0]   count_push_s;

   // Advance a queue pointer, wrapping modulo DEPTH.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == PW'(DEPTH - 1)) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + PW'(1);
      end
      return nxt;
   endfunction

   // Low two bits of a redirect target are forced to zero (word aligned).
   assign redir_pc_s   = bus.redirect_pc & 32'hFFFF_FFFC;
   assign req_pc_inc_s = req_pc_q + 32'd4;

   // A redirect blocks the pop: the head belongs to the squashed path.
   assign pop_s   = (count_q != {CW{1'b0}}) & bus.inst_ready & ~bus.redirect;
   assign flush_s = bus.redirect;

   // Occupancy after this cycle's pop, and after pop plus an accepted ack;
   // one extra bit so the +1 can never wrap.
   assign count_pop_s  = {1'b0, count_q} - {{CW{1'b0}}, pop_s};
   assign count_push_s = count_pop_s + {{CW{1'b0}}, 1'b1};

   // Fetch FSM: next state, next fetch PC, request address and push decision.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      push_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.redirect) begin
               fetch_pc_d = redir_pc_s;
               req_pc_d   = redir_pc_s;
               state_d    = WAIT;
            end else if (count_pop_s < (CW+1)'(DEPTH)) begin
               req_pc_d = fetch_pc_q;
               state_d  = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (bus.imem_ack) begin
               if (bus.redirect) begin
                  // Returned word is on the squashed path: drop it and
                  // restart immediately at the redirect target.
                  fetch_pc_d = redir_pc_s;
                  req_pc_d   = redir_pc_s;
                  state_d    = WAIT;
               end else begin
                  push_s     = 1'b1;
                  fetch_pc_d = req_pc_inc_s;
                  if (count_push_s < (CW+1)'(DEPTH)) begin
                     req_pc_d = req_pc_inc_s;
                     state_d  = WAIT;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (bus.redirect) begin
               // Request stays up with its old address until memory answers.
               fetch_pc_d = redir_pc_s;
               state_d    = DISCARD;
            end else begin
               state_d = WAIT;
            end
         end
         DISCARD: begin
            if (bus.imem_ack) begin
               state_d = WAIT;
               if (bus.redirect) begin
                  fetch_pc_d = redir_pc_s;
                  req_pc_d   = redir_pc_s;
               end else begin
                  req_pc_d = fetch_pc_q;
               end
            end else if (bus.redirect) begin
               fetch_pc_d = redir_pc_s;
            end else begin
               state_d = DISCARD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req_d = (state_d != IDLE);
   end

   // Queue bookkeeping: flush on redirect, else pop at head and push at tail.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      if (flush_s) begin
         head_d  = {PW{1'b0}};
         tail_d  = {PW{1'b0}};
         count_d = {CW{1'b0}};
      end else begin
         if (pop_s) begin
            head_d = next_ptr(head_q);
         end else begin
            head_d = head_q;
         end
         if (push_s) begin
            pc_mem_d[tail_q]   = req_pc_q;
            inst_mem_d[tail_q] = bus.imem_rdata;
            tail_d             = next_ptr(tail_q);
         end else begin
            tail_d = tail_q;
         end
         count_d = count_q - CW'(pop_s) + CW'(push_s);
      end
      valid_d = (count_d != {CW{1'b0}});
   end

   // State, PC and queue registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         head_q     <= {PW{1'b0}};
         tail_q     <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= 32'h0000_0000;
            inst_mem_q[i] <= 32'h0000_0000;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         req_q      <= req_d;
         valid_q    <= valid_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
      end
   end

   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = req_pc_q;
   assign bus.inst_valid = valid_q;
   assign bus.inst       = inst_mem_q[head_q];
   assign bus.inst_pc    = pc_mem_q[head_q];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a memory responder with random latency, a random
// consumer and random redirects, checked every cycle against a queue-based
// reference model, plus directed boundary scenarios.
module tb_inst_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   logic clk;
   logic rst;
   inst_fetch_if bus ();

   inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pending words as a queue, plus fetch bookkeeping.
   ent_t        mq[$];
   bit          m_busy;
   bit          m_drop;
   logic [31:0] m_addr;
   logic [31:0] m_fetch;
   int          lat;
   bit          ack_force;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy  = 1'b0;
      m_drop  = 1'b0;
      m_addr  = RESET_PC;
      m_fetch = RESET_PC;
   endtask

   // One clock of the fetch rules, given this cycle's inputs.
   task automatic model_step(input bit ack, input bit redir, input bit ready, input logic [31:0] rpc);
      logic [31:0] rp;
      rp = rpc & 32'hFFFF_FFFC;
      if (mq.size() != 0 && ready && !redir) void'(mq.pop_front());
      if (redir) mq.delete();
      if (!m_busy) begin
         if (redir) begin
            m_fetch = rp;
            m_addr  = rp;
            m_busy  = 1'b1;
         end else if (mq.size() < DEPTH) begin
            m_addr = m_fetch;
            m_busy = 1'b1;
         end
      end else if (!m_drop) begin
         if (ack && !redir) begin
            mq.push_back({m_addr, memf(m_addr)});
            m_fetch = m_addr + 32'd4;
            if (mq.size() < DEPTH) m_addr = m_fetch;
            else m_busy = 1'b0;
         end else if (ack) begin
            m_addr  = rp;
            m_fetch = rp;
         end else if (redir) begin
            m_fetch = rp;
            m_drop  = 1'b1;
         end
      end else begin
         if (redir) m_fetch = rp;
         if (ack) begin
            m_drop = 1'b0;
            m_addr = m_fetch;
         end
      end
   endtask

   task automatic compare_outputs();
      check_eq("imem_req", {31'd0, bus.imem_req}, {31'd0, m_busy});
      check_eq("imem_addr", bus.imem_addr, m_addr);
      check_eq("inst_valid", {31'd0, bus.inst_valid}, {31'd0, (mq.size() != 0)});
      if (mq.size() != 0) begin
         check_eq("inst", bus.inst, mq[0].ins);
         check_eq("inst_pc", bus.inst_pc, mq[0].pc);
      end
   endtask

   // Called at a falling edge: check, drive inputs, advance model, wait one clock.
   task automatic cycle(input bit redir, input bit ready, input logic [31:0] rpc, input int maxlat);
      bit ack;
      compare_outputs();
      if (ack_force) ack = 1'b1;
      else if (m_busy) ack = (lat == 0);
      else ack = ($urandom_range(0, 3) == 0);
      bus.imem_ack    = ack;
      bus.imem_rdata  = ack ? memf(m_addr) : $urandom;
      bus.inst_ready  = ready;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      if (!m_busy) lat = $urandom_range(0, maxlat);
      else if (ack) lat = $urandom_range(0, maxlat);
      else if (lat > 0) lat--;
      model_step(ack, redir, ready, rpc);
      @(negedge clk);
   endtask

   // Asynchronous reset between edges while a request is up; a late ack
   // is presented during and just after reset.
   task automatic do_reset();
      #2;
      rst          = 1'b1;
      bus.imem_ack = 1'b1;
      #1;
      check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
      check_eq("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
      check_eq("rst_addr", bus.imem_addr, RESET_PC);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] pick_rpc();
      logic [31:0] r;
      case ($urandom_range(0, 4))
         0: r = 32'h0000_3400;
         1: r = 32'h0000_3101;
         2: r = 32'hFFFF_FFF8;
         3: r = 32'hFFFF_FFFE;
         default: r = $urandom;
      endcase
      return r;
   endfunction

   initial begin
      rst             = 1'b1;
      ack_force       = 1'b0;
      lat             = 0;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.inst_ready  = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      model_reset();
      #12;
      check_eq("reset_req", {31'd0, bus.imem_req}, 32'd0);
      check_eq("reset_valid", {31'd0, bus.inst_valid}, 32'd0);
      check_eq("reset_addr", bus.imem_addr, 32'h0000_3000);
      check_eq("reset_inst", bus.inst, 32'h0);
      check_eq("reset_inst_pc", bus.inst_pc, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Streaming: ack every cycle, consumer always ready.
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b1, 32'h0, 0);
         if (i == 0) check_eq("first_addr", bus.imem_addr, 32'h0000_3000);
         if (i == 1) check_eq("first_inst_pc", bus.inst_pc, 32'h0000_3000);
         if (i == 2) check_eq("stream_addr", bus.imem_addr, 32'h0000_3008);
      end

      // Back-pressure fills the queue, request drops; then resume.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 0);
      check_eq("full_req", {31'd0, bus.imem_req}, 32'd0);
      check_eq("full_valid", {31'd0, bus.inst_valid}, 32'd1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h0, 0);

      // Reset while a request is up; restart at RESET_PC.
      do_reset();

      // Latency 3, redirect to 0x3400 in the second wait cycle.
      cycle(1'b0, 1'b1, 32'h0, 0);
      lat = 2;
      cycle(1'b0, 1'b1, 32'h0, 0);
      cycle(1'b1, 1'b1, 32'h0000_3400, 0);
      cycle(1'b0, 1'b1, 32'h0, 0);
      check_eq("redir_addr", bus.imem_addr, 32'h0000_3400);
      check_eq("redir_req", {31'd0, bus.imem_req}, 32'd1);
      cycle(1'b0, 1'b0, 32'h0, 0);
      check_eq("redir_first_pc", bus.inst_pc, 32'h0000_3400);

      // Fill the queue, then redirect to 0x3101 with ack and ready.
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 0);
      check_eq("full2_valid", {31'd0, bus.inst_valid}, 32'd1);
      ack_force = 1'b1;
      cycle(1'b1, 1'b1, 32'h0000_3101, 0);
      ack_force = 1'b0;
      check_eq("flush_valid", {31'd0, bus.inst_valid}, 32'd0);
      check_eq("flush_addr", bus.imem_addr, 32'h0000_3100);

      // PC wrap at the top of the address space.
      cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 0);
      cycle(1'b0, 1'b1, 32'h0, 0);
      check_eq("wrap_addr", bus.imem_addr, 32'h0000_0000);
      check_eq("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
               pick_rpc(), $urandom_range(0, 3));
      end
      compare_outputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      n_errors++;
      $display("FAIL watchdog: run did not complete, time %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
